// File: rtl/reorder_buffer.sv
// Circular in-order-retire reorder buffer: dispatch allocates at tail, CDB marks done, commit retires head.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB data to the operand query ports.
module reorder_buffer #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        dis_valid,
  output logic        dis_ready,
  input  logic [2:0]  dis_op_type,
  input  logic [4:0]  dis_rd_addr,
  input  logic        dis_regf_we,
  input  logic [31:0] dis_pc,
  output logic [4:0]  dis_rob_idx,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_rob_idx,
  input  logic [31:0] cdb_data,
  input  logic [4:0]  q1_rob_idx,
  input  logic [4:0]  q2_rob_idx,
  output logic        q1_ready,
  output logic        q2_ready,
  output logic [31:0] q1_data,
  output logic [31:0] q2_data,
  output logic        commit_valid,
  output logic        commit_regf_we,
  output logic [4:0]  commit_rd_addr,
  output logic [4:0]  commit_rob_idx,
  output logic [31:0] commit_data,
  output logic [31:0] commit_pc,
  output logic        rob_empty,
  output logic [5:0]  rob_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {empty, rob_wait, done} status_t;
  typedef logic [2:0] types_t;

  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] pc;
    logic [31:0] rd_data;
    logic [4:0]  rd_rob_idx;
  } rob_entry_t;

  localparam rob_entry_t ENTRY_CLR = '{valid: 1'b0, status: empty, op_type: 3'd0,
                                       rd_addr: 5'd0, regf_we: 1'b0, pc: 32'd0,
                                       rd_data: 32'd0, rd_rob_idx: 5'd0};

  rob_entry_t  rob_q [DEPTH];
  rob_entry_t  rob_d [DEPTH];
  logic [5:0]  head_q, head_d;
  logic [5:0]  tail_q, tail_d;
  logic        commit_valid_q, commit_valid_d;
  logic        commit_regf_we_q, commit_regf_we_d;
  logic [4:0]  commit_rd_addr_q, commit_rd_addr_d;
  logic [4:0]  commit_rob_idx_q, commit_rob_idx_d;
  logic [31:0] commit_data_q, commit_data_d;
  logic [31:0] commit_pc_q, commit_pc_d;

  logic        full;
  logic        is_empty;
  logic        dis_fire;
  logic        commit_fire;
  logic        cdb_hit;
  rob_entry_t  head_entry;

  // Pointer low bits index the entry; bit 5 toggles each time the low bits wrap past DEPTH-1.
  function automatic logic [5:0] ptr_inc(input logic [5:0] p);
    if (p[4:0] == 5'(DEPTH - 1)) return {~p[5], 5'd0};
    return {p[5], p[4:0] + 5'd1};
  endfunction

  function automatic logic [AW-1:0] slot(input logic [4:0] idx);
    return idx[AW-1:0];
  endfunction

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < 6'(DEPTH);
  endfunction

  function automatic logic [32:0] query(input logic [4:0] idx);
    logic [32:0] r;
    r = '0;
    if (in_range(idx)) begin
      if (rob_q[slot(idx)].status == done) begin
        r = {1'b1, rob_q[slot(idx)].rd_data};
      end
`ifdef ROB_CDB_BYPASS_EN
      else if (rob_q[slot(idx)].status == rob_wait && cdb_valid && cdb_rob_idx == idx) begin
        r = {1'b1, cdb_data};
      end
`endif
    end
    return r;
  endfunction

  always_comb begin
    full        = (head_q[4:0] == tail_q[4:0]) && (head_q[5] != tail_q[5]);
    is_empty    = (head_q == tail_q);
    dis_fire    = dis_valid && !full;
    head_entry  = rob_q[slot(head_q[4:0])];
    commit_fire = !is_empty && (head_entry.status == done);
    cdb_hit     = cdb_valid && in_range(cdb_rob_idx) &&
                  (rob_q[slot(cdb_rob_idx)].status == rob_wait);
  end

  // Commit, CDB and dispatch never touch the same entry in one cycle, so they can be applied in sequence.
  always_comb begin
    rob_d            = rob_q;
    head_d           = head_q;
    tail_d           = tail_q;
    commit_valid_d   = 1'b0;
    commit_regf_we_d = commit_regf_we_q;
    commit_rd_addr_d = commit_rd_addr_q;
    commit_rob_idx_d = commit_rob_idx_q;
    commit_data_d    = commit_data_q;
    commit_pc_d      = commit_pc_q;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) rob_d[i] = ENTRY_CLR;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit_fire) begin
        commit_valid_d   = 1'b1;
        commit_regf_we_d = head_entry.regf_we;
        commit_rd_addr_d = head_entry.rd_addr;
        commit_rob_idx_d = head_entry.rd_rob_idx;
        commit_data_d    = head_entry.rd_data;
        commit_pc_d      = head_entry.pc;
        rob_d[slot(head_q[4:0])].valid  = 1'b0;
        rob_d[slot(head_q[4:0])].status = empty;
        head_d = ptr_inc(head_q);
      end
      if (cdb_hit) begin
        rob_d[slot(cdb_rob_idx)].rd_data = cdb_data;
        rob_d[slot(cdb_rob_idx)].status  = done;
      end
      if (dis_fire) begin
        rob_d[slot(tail_q[4:0])] = '{valid: 1'b1, status: rob_wait, op_type: dis_op_type,
                                     rd_addr: dis_rd_addr, regf_we: dis_regf_we, pc: dis_pc,
                                     rd_data: 32'd0, rd_rob_idx: tail_q[4:0]};
        tail_d = ptr_inc(tail_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) rob_q[i] <= ENTRY_CLR;
      head_q           <= '0;
      tail_q           <= '0;
      commit_valid_q   <= 1'b0;
      commit_regf_we_q <= 1'b0;
      commit_rd_addr_q <= '0;
      commit_rob_idx_q <= '0;
      commit_data_q    <= '0;
      commit_pc_q      <= '0;
    end else begin
      rob_q            <= rob_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      commit_valid_q   <= commit_valid_d;
      commit_regf_we_q <= commit_regf_we_d;
      commit_rd_addr_q <= commit_rd_addr_d;
      commit_rob_idx_q <= commit_rob_idx_d;
      commit_data_q    <= commit_data_d;
      commit_pc_q      <= commit_pc_d;
    end
  end

  always_comb begin
    dis_ready      = !full;
    dis_rob_idx    = tail_q[4:0];
    rob_empty      = is_empty;
    rob_count      = (tail_q[5] == head_q[5]) ?
                     ({1'b0, tail_q[4:0]} - {1'b0, head_q[4:0]}) :
                     (6'(DEPTH) + {1'b0, tail_q[4:0]} - {1'b0, head_q[4:0]});
    {q1_ready, q1_data} = query(q1_rob_idx);
    {q2_ready, q2_data} = query(q2_rob_idx);
    commit_valid   = commit_valid_q;
    commit_regf_we = commit_regf_we_q;
    commit_rd_addr = commit_rd_addr_q;
    commit_rob_idx = commit_rob_idx_q;
    commit_data    = commit_data_q;
    commit_pc      = commit_pc_q;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order completion, wrap, query, flush, reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n, flush, dis_valid, dis_ready, dis_regf_we;
  logic [2:0]  dis_op_type;
  logic [4:0]  dis_rd_addr, dis_rob_idx, cdb_rob_idx, q1_rob_idx, q2_rob_idx;
  logic [31:0] dis_pc, cdb_data, q1_data, q2_data;
  logic        cdb_valid, q1_ready, q2_ready;
  logic        commit_valid, commit_regf_we;
  logic [4:0]  commit_rd_addr, commit_rob_idx;
  logic [31:0] commit_data, commit_pc;
  logic        rob_empty;
  logic [5:0]  rob_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_op_type(dis_op_type),
    .dis_rd_addr(dis_rd_addr), .dis_regf_we(dis_regf_we), .dis_pc(dis_pc),
    .dis_rob_idx(dis_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .q1_rob_idx(q1_rob_idx), .q2_rob_idx(q2_rob_idx),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_regf_we(commit_regf_we),
    .commit_rd_addr(commit_rd_addr), .commit_rob_idx(commit_rob_idx),
    .commit_data(commit_data), .commit_pc(commit_pc),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; dis_valid = 1'b0; dis_op_type = 3'd0; dis_rd_addr = 5'd0;
    dis_regf_we = 1'b0; dis_pc = 32'd0; cdb_valid = 1'b0; cdb_rob_idx = 5'd0;
    cdb_data = 32'd0; q1_rob_idx = 5'd0; q2_rob_idx = 5'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc);
    dis_valid = 1'b1; dis_rd_addr = rd; dis_regf_we = 1'b1; dis_op_type = 3'd1; dis_pc = pc;
    step();
    dis_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] idx, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_rob_idx = idx; cdb_data = data;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (commit_valid !== 1'b0) begin failed++; $display("FAIL reset_commit_valid got %b exp 0", commit_valid); end
    tests++; if (commit_data !== 32'd0) begin failed++; $display("FAIL reset_commit_data got %h exp 0", commit_data); end
    tests++; if (commit_pc !== 32'd0) begin failed++; $display("FAIL reset_commit_pc got %h exp 0", commit_pc); end
    tests++; if (dis_rob_idx !== 5'd0) begin failed++; $display("FAIL reset_dis_rob_idx got %0d exp 0", dis_rob_idx); end
    tests++; if (rob_empty !== 1'b1) begin failed++; $display("FAIL reset_rob_empty got %b exp 1", rob_empty); end
    tests++; if (rob_count !== 6'd0) begin failed++; $display("FAIL reset_rob_count got %0d exp 0", rob_count); end
    tests++; if (dis_ready !== 1'b1) begin failed++; $display("FAIL reset_dis_ready got %b exp 1", dis_ready); end
    tests++; if (q1_ready !== 1'b0 || q1_data !== 32'd0) begin failed++; $display("FAIL reset_q1 got %b/%h exp 0/0", q1_ready, q1_data); end
  endtask

  task automatic test_basic_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dis_valid = 1'b1; dis_rd_addr = 5'(i + 1); dis_regf_we = 1'b1; dis_pc = 32'h100 + 32'(4 * i);
      #1;
      tests++; if (dis_rob_idx !== 5'(i)) begin failed++; $display("FAIL basic_alloc_idx got %0d exp %0d", dis_rob_idx, i); end
      step();
    end
    dis_valid = 1'b0;
    tests++; if (rob_count !== 6'd3) begin failed++; $display("FAIL basic_count got %0d exp 3", rob_count); end
    cdb(5'd0, 32'hAAAA_0001);
    tests++; if (commit_valid !== 1'b0) begin failed++; $display("FAIL basic_commit_early got %b exp 0", commit_valid); end
    step();
    tests++; if (commit_valid !== 1'b1) begin failed++; $display("FAIL basic_commit_valid got %b exp 1", commit_valid); end
    tests++; if (commit_rd_addr !== 5'd1) begin failed++; $display("FAIL basic_commit_rd got %0d exp 1", commit_rd_addr); end
    tests++; if (commit_data !== 32'hAAAA_0001) begin failed++; $display("FAIL basic_commit_data got %h exp aaaa0001", commit_data); end
    tests++; if (commit_rob_idx !== 5'd0) begin failed++; $display("FAIL basic_commit_idx got %0d exp 0", commit_rob_idx); end
    tests++; if (commit_pc !== 32'h100 || commit_regf_we !== 1'b1) begin failed++; $display("FAIL basic_commit_pc_we got %h/%b exp 100/1", commit_pc, commit_regf_we); end
    tests++; if (rob_count !== 6'd2) begin failed++; $display("FAIL basic_count_after got %0d exp 2", rob_count); end
    step();
    tests++; if (commit_valid !== 1'b0 || commit_data !== 32'hAAAA_0001) begin failed++; $display("FAIL basic_commit_hold got %b/%h exp 0/aaaa0001", commit_valid, commit_data); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h10; exp_data[1] = 32'h11; exp_data[2] = 32'h22;
    do_reset();
    for (int i = 0; i < 3; i++) dispatch(5'(i + 1), 32'h200 + 32'(4 * i));
    cdb(5'd2, 32'h22);
    cdb(5'd1, 32'h11);
    cdb(5'd0, 32'h10);
    tests++; if (commit_valid !== 1'b0) begin failed++; $display("FAIL ooo_no_early_commit got %b exp 0", commit_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (commit_valid !== 1'b1 || commit_rob_idx !== 5'(i) || commit_data !== exp_data[i] || commit_rd_addr !== 5'(i + 1)) begin
        failed++;
        $display("FAIL ooo_commit_%0d got v=%b idx=%0d d=%h rd=%0d exp v=1 idx=%0d d=%h rd=%0d",
                 i, commit_valid, commit_rob_idx, commit_data, commit_rd_addr, i, exp_data[i], i + 1);
      end
    end
    step();
    tests++; if (commit_valid !== 1'b0 || rob_empty !== 1'b1) begin failed++; $display("FAIL ooo_drained got v=%b empty=%b exp 0/1", commit_valid, rob_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tests++; if (dis_rob_idx !== 5'(i) || dis_ready !== 1'b1) begin failed++; $display("FAIL wrap_fill_%0d got idx=%0d rdy=%b exp %0d/1", i, dis_rob_idx, dis_ready, i); end
      dispatch(5'(i), 32'(4 * i));
    end
    tests++; if (dis_ready !== 1'b0) begin failed++; $display("FAIL wrap_full_ready got %b exp 0", dis_ready); end
    tests++; if (rob_count !== 6'd32 || rob_empty !== 1'b0) begin failed++; $display("FAIL wrap_full_count got %0d/%b exp 32/0", rob_count, rob_empty); end
    dispatch(5'd30, 32'hDEAD);
    tests++; if (rob_count !== 6'd32) begin failed++; $display("FAIL wrap_overflow_dropped got %0d exp 32", rob_count); end
    cdb(5'd0, 32'hC0);
    dis_valid = 1'b1; dis_rd_addr = 5'd9; dis_pc = 32'hBEEF;
    #1;
    tests++; if (dis_ready !== 1'b0) begin failed++; $display("FAIL wrap_commit_no_free got %b exp 0", dis_ready); end
    step();
    dis_valid = 1'b0;
    tests++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'd0 || commit_data !== 32'hC0) begin failed++; $display("FAIL wrap_commit got v=%b idx=%0d d=%h exp 1/0/c0", commit_valid, commit_rob_idx, commit_data); end
    tests++; if (rob_count !== 6'd31 || dis_ready !== 1'b1) begin failed++; $display("FAIL wrap_after_commit got cnt=%0d rdy=%b exp 31/1", rob_count, dis_ready); end
    tests++; if (dis_rob_idx !== 5'd0) begin failed++; $display("FAIL wrap_next_idx got %0d exp 0", dis_rob_idx); end
    dispatch(5'd9, 32'h400);
    tests++; if (rob_count !== 6'd32 || dis_ready !== 1'b0 || dis_rob_idx !== 5'd1) begin failed++; $display("FAIL wrap_refull got cnt=%0d rdy=%b idx=%0d exp 32/0/1", rob_count, dis_ready, dis_rob_idx); end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 6; i++) dispatch(5'(i + 1), 32'h300 + 32'(4 * i));
    q1_rob_idx = 5'd5; q2_rob_idx = 5'd4;
    cdb_valid = 1'b1; cdb_rob_idx = 5'd5; cdb_data = 32'h1234;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    tests++; if (q1_ready !== 1'b1 || q1_data !== 32'h1234) begin failed++; $display("FAIL query_bypass got %b/%h exp 1/1234", q1_ready, q1_data); end
`else
    tests++; if (q1_ready !== 1'b0 || q1_data !== 32'h0) begin failed++; $display("FAIL query_no_bypass got %b/%h exp 0/0", q1_ready, q1_data); end
`endif
    tests++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin failed++; $display("FAIL query_wait_entry got %b/%h exp 0/0", q2_ready, q2_data); end
    step();
    cdb_valid = 1'b0;
    #1;
    tests++; if (q1_ready !== 1'b1 || q1_data !== 32'h1234) begin failed++; $display("FAIL query_done got %b/%h exp 1/1234", q1_ready, q1_data); end
    cdb(5'd5, 32'h9999);
    q2_rob_idx = 5'd5;
    #1;
    tests++; if (q1_data !== 32'h1234 || q2_ready !== 1'b1 || q2_data !== 32'h1234) begin failed++; $display("FAIL query_done_ignores_cdb got %h/%b/%h exp 1234/1/1234", q1_data, q2_ready, q2_data); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) dispatch(5'(i), 32'h500 + 32'(4 * i));
    cdb(5'd0, 32'h55);
    tests++; if (rob_count !== 6'd10) begin failed++; $display("FAIL flush_pre_count got %0d exp 10", rob_count); end
    flush = 1'b1; dis_valid = 1'b1; dis_rd_addr = 5'd7; dis_pc = 32'h777;
    cdb_valid = 1'b1; cdb_rob_idx = 5'd3; cdb_data = 32'h33;
    step();
    flush = 1'b0; dis_valid = 1'b0; cdb_valid = 1'b0;
    tests++; if (rob_empty !== 1'b1 || rob_count !== 6'd0) begin failed++; $display("FAIL flush_empty got %b/%0d exp 1/0", rob_empty, rob_count); end
    tests++; if (commit_valid !== 1'b0) begin failed++; $display("FAIL flush_no_commit got %b exp 0", commit_valid); end
    tests++; if (dis_rob_idx !== 5'd0 || dis_ready !== 1'b1) begin failed++; $display("FAIL flush_ptrs got %0d/%b exp 0/1", dis_rob_idx, dis_ready); end
    q1_rob_idx = 5'd3;
    cdb_valid = 1'b1; cdb_rob_idx = 5'd3; cdb_data = 32'hDEAD;
    #1;
    tests++; if (q1_ready !== 1'b0) begin failed++; $display("FAIL flush_stale_bypass got %b exp 0", q1_ready); end
    step();
    cdb_valid = 1'b0;
    #1;
    tests++; if (q1_ready !== 1'b0 || rob_count !== 6'd0) begin failed++; $display("FAIL flush_stale_cdb got %b/%0d exp 0/0", q1_ready, rob_count); end
    step();
    tests++; if (commit_valid !== 1'b0 || rob_empty !== 1'b1) begin failed++; $display("FAIL flush_quiet got %b/%b exp 0/1", commit_valid, rob_empty); end
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'(i + 4), 32'h600 + 32'(4 * i));
    for (int i = 0; i < 4; i++) cdb(5'(i), 32'hF0 + 32'(i));
    tests++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'd2 || commit_data !== 32'hF2) begin failed++; $display("FAIL midrst_stream got v=%b idx=%0d d=%h exp 1/2/f2", commit_valid, commit_rob_idx, commit_data); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++; if (commit_valid !== 1'b0 || commit_data !== 32'd0 || commit_pc !== 32'd0 || commit_rd_addr !== 5'd0 || commit_rob_idx !== 5'd0 || commit_regf_we !== 1'b0) begin
      failed++; $display("FAIL midrst_commit got v=%b d=%h pc=%h rd=%0d idx=%0d we=%b exp all 0", commit_valid, commit_data, commit_pc, commit_rd_addr, commit_rob_idx, commit_regf_we);
    end
    tests++; if (rob_empty !== 1'b1 || rob_count !== 6'd0 || dis_ready !== 1'b1 || dis_rob_idx !== 5'd0) begin
      failed++; $display("FAIL midrst_state got e=%b cnt=%0d rdy=%b idx=%0d exp 1/0/1/0", rob_empty, rob_count, dis_ready, dis_rob_idx);
    end
    step();
    tests++; if (commit_valid !== 1'b0) begin failed++; $display("FAIL midrst_no_resume got %b exp 0", commit_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_commit();
    test_out_of_order();
    test_full_wrap();
    test_query();
    test_flush();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
